// File: rtl/row_word_unpacker.sv
// row_word_unpacker: buffers parallel camera row words and serialises them
// into a valid/ready pixel stream with row/frame framing flags and indices.
module row_word_unpacker #(
  parameter int unsigned WORD_W         = 208,
  parameter int unsigned PIX_W          = 8,
  parameter int unsigned ROWS_PER_FRAME = 24,
  parameter int unsigned DEPTH          = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              din_vald,
  input  logic [WORD_W-1:0] din,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_vld,
  input  logic              pix_rdy,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic [4:0]        col_idx,
  output logic [4:0]        row_idx,
  output logic [1:0]        level,
  output logic              overflow
);

  localparam int unsigned PIX_PER_WORD = WORD_W / PIX_W;
  localparam int unsigned PTR_W        = $clog2(DEPTH);
  localparam int unsigned IDX_W        = 5;
  localparam int unsigned LVL_W        = 2;

  localparam logic [0:0] S_EMPTY  = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  col_q, col_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic              overflow_q, overflow_d;

  logic              xfer_c;
  logic              last_col_c;
  logic              free_c;
  logic              full_c;
  logic              push_req_c;
  logic              wr_c;
  logic              drop_c;
  logic [WORD_W-1:0] head_c;
  logic [PIX_W-1:0]  pix_sel_c;

  // Handshake, buffer occupancy and write/drop qualification
  always_comb begin
    xfer_c     = (state_q == S_STREAM) && pix_rdy;
    last_col_c = (col_q == IDX_W'(PIX_PER_WORD - 1));
    free_c     = xfer_c && last_col_c;
    full_c     = (level_q == LVL_W'(DEPTH));
    push_req_c = en && din_vald;
    wr_c       = push_req_c && (!full_c || free_c);
    drop_c     = push_req_c && full_c && !free_c;
  end

  // Select the current pixel out of the head row word
  always_comb begin
    head_c    = mem_q[rd_ptr_q];
    pix_sel_c = '0;
    for (int i = 0; i < int'(PIX_PER_WORD); i++) begin
      if (col_q == IDX_W'(i)) begin
        pix_sel_c = head_c[i*PIX_W +: PIX_W];
      end
    end
  end

  // Next-state: pointers, level, FSM, indices and sticky overflow
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    overflow_d = overflow_q;

    if (wr_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (free_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({wr_c, free_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop_c) begin
      overflow_d = 1'b1;
    end

    if (xfer_c) begin
      if (last_col_c) begin
        col_d = '0;
        if (row_q == IDX_W'(ROWS_PER_FRAME - 1)) begin
          row_d = '0;
        end else begin
          row_d = row_q + IDX_W'(1);
        end
      end else begin
        col_d = col_q + IDX_W'(1);
      end
    end

    case (state_q)
      S_EMPTY: begin
        // One bubble cycle after a write into an empty buffer
        if (level_q != '0) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (free_c && (level_d == '0)) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= S_EMPTY;
      col_q      <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
    end
  end

  // Row word storage; contents need no reset since level gates reads
  always_ff @(posedge clk) begin
    if (wr_c && !rst) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Output decode of registered state; flags gated by pix_vld
  always_comb begin
    pix_vld  = (state_q == S_STREAM);
    pix_data = pix_vld ? pix_sel_c : '0;
    pix_sol  = pix_vld && (col_q == '0);
    pix_eol  = pix_vld && last_col_c;
    pix_sof  = pix_sol && (row_q == '0);
    pix_eof  = pix_eol && (row_q == IDX_W'(ROWS_PER_FRAME - 1));
    col_idx  = col_q;
    row_idx  = row_q;
    level    = level_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_row_word_unpacker.sv
// Scoreboard bench for row_word_unpacker: stimulus pushes expected pixels,
// a negedge monitor pops and compares on every pix_vld && pix_rdy transfer.
module tb_row_word_unpacker;

  localparam int WORD_W = 208;
  localparam int PIX_W  = 8;
  localparam int PPW    = 26;
  localparam int RPF    = 24;

  logic              clk;
  logic              rst;
  logic              en;
  logic              din_vald;
  logic [WORD_W-1:0] din;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_vld;
  logic              pix_rdy;
  logic              pix_sol;
  logic              pix_eol;
  logic              pix_sof;
  logic              pix_eof;
  logic [4:0]        col_idx;
  logic [4:0]        row_idx;
  logic [1:0]        level;
  logic              overflow;

  row_word_unpacker #(
    .WORD_W(WORD_W), .PIX_W(PIX_W), .ROWS_PER_FRAME(RPF), .DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din_vald(din_vald), .din(din),
    .pix_data(pix_data), .pix_vld(pix_vld), .pix_rdy(pix_rdy),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .col_idx(col_idx), .row_idx(row_idx), .level(level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         col;
    int         row;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   exp_row;
  int   run_len;
  int   max_run;
  int   sof_cnt;
  int   eof_cnt;
  logic stall;
  logic [7:0] held_data;
  logic [4:0] held_col;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] mk_word(input int base);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < PPW; k++) w[k*8 +: 8] = 8'(base + k);
    return w;
  endfunction

  // Drive one row word for one cycle; queue its pixels if it should be accepted
  task automatic send(input int base, input bit accept);
    exp_t e;
    din      = mk_word(base);
    din_vald = 1'b1;
    if (accept) begin
      for (int k = 0; k < PPW; k++) begin
        e.data = 8'(base + k);
        e.col  = k;
        e.row  = exp_row;
        sb.push_back(e);
      end
      exp_row = (exp_row + 1) % RPF;
    end
    @(posedge clk); #1;
    din_vald = 1'b0;
  endtask

  // Run until the scoreboard is empty and the stream idle; bp applies 1,0,0,1
  task automatic wait_drain(input bit bp);
    bit done;
    int ph;
    done = 1'b0;
    ph   = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (bp) pix_rdy = ((ph % 4) == 0) || ((ph % 4) == 3);
      ph++;
      @(posedge clk); #1;
      if (sb.size() == 0 && !pix_vld) done = 1'b1;
    end
    pix_rdy = 1'b1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d pixels still expected, pix_vld=%0d", sb.size(), pix_vld);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    exp_row = 0;
  endtask

  // Monitor: pop and compare on every transfer, verify holding under stall
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall   = 1'b0;
      run_len = 0;
    end else begin
      if (stall && pix_vld) begin
        check("hold_data", 32'(pix_data), 32'(held_data));
        check("hold_col", 32'(col_idx), 32'(held_col));
      end
      if (pix_vld) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (pix_vld && pix_rdy) begin
        if (pix_sof) sof_cnt++;
        if (pix_eof) eof_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got data %0d col %0d row %0d, expected none",
                   pix_data, col_idx, row_idx);
        end else begin
          e = sb.pop_front();
          check("pix_data", 32'(pix_data), 32'(e.data));
          check("col_idx", 32'(col_idx), e.col);
          check("row_idx", 32'(row_idx), e.row);
          check("pix_sol", 32'(pix_sol), (e.col == 0) ? 1 : 0);
          check("pix_eol", 32'(pix_eol), (e.col == PPW - 1) ? 1 : 0);
          check("pix_sof", 32'(pix_sof), (e.col == 0 && e.row == 0) ? 1 : 0);
          check("pix_eof", 32'(pix_eof), (e.col == PPW - 1 && e.row == RPF - 1) ? 1 : 0);
        end
      end
      stall     = pix_vld && !pix_rdy;
      held_data = pix_data;
      held_col  = col_idx;
    end
  end

  initial begin
    bit found;
    checks = 0; errors = 0; exp_row = 0;
    run_len = 0; max_run = 0; sof_cnt = 0; eof_cnt = 0;
    stall = 1'b0; held_data = '0; held_col = '0;
    rst = 1'b1; en = 1'b1; din_vald = 1'b0; din = '0; pix_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 32'(pix_vld), 0);
    check("rst_data", 32'(pix_data), 0);
    check("rst_flags", 32'({pix_sol, pix_eol, pix_sof, pix_eof}), 0);
    check("rst_col", 32'(col_idx), 0);
    check("rst_row", 32'(row_idx), 0);
    check("rst_level", 32'(level), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;

    // Single word: one bubble then pixels 0..25
    send(0, 1'b1);
    check("bubble_vld", 32'(pix_vld), 0);
    check("bubble_level", 32'(level), 1);
    @(posedge clk); #1;
    check("first_vld", 32'(pix_vld), 1);
    check("first_data", 32'(pix_data), 0);
    check("first_sof", 32'(pix_sof), 1);
    wait_drain(1'b0);
    check("single_end_level", 32'(level), 0);
    check("single_end_vld", 32'(pix_vld), 0);

    // Back-to-back words 10 cycles apart: 52 contiguous pixels
    do_reset();
    max_run = 0;
    send(32, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    send(64, 1'b1);
    wait_drain(1'b0);
    check("b2b_run_len", max_run, 2 * PPW);

    // Backpressure with rdy pattern 1,0,0,1
    pix_rdy = 1'b0;
    send(100, 1'b1);
    send(140, 1'b1);
    wait_drain(1'b1);

    // Overflow: third word dropped while stalled
    pix_rdy = 1'b0;
    send(170, 1'b1);
    send(200, 1'b1);
    send(230, 1'b0);
    check("ovf_level", 32'(level), 2);
    check("ovf_flag", 32'(overflow), 1);
    pix_rdy = 1'b1;
    wait_drain(1'b0);

    // en low: strobe ignored
    en = 1'b0;
    send(7, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("en_low_level", 32'(level), 0);
    check("en_low_vld", 32'(pix_vld), 0);
    en = 1'b1;

    // Reset mid-row at pixel 10 of row 3
    while (exp_row != 3) begin
      send(exp_row * 7, 1'b1);
      wait_drain(1'b0);
    end
    check("pre_rst_overflow", 32'(overflow), 1);
    send(90, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (pix_vld && col_idx == 5'd10 && row_idx == 5'd3) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("mid_row_reached", 32'(found), 1);
    do_reset();
    check("mrst_vld", 32'(pix_vld), 0);
    check("mrst_level", 32'(level), 0);
    check("mrst_overflow", 32'(overflow), 0);
    check("mrst_col", 32'(col_idx), 0);
    check("mrst_row", 32'(row_idx), 0);
    send(50, 1'b1);
    @(posedge clk); #1;
    check("post_rst_vld", 32'(pix_vld), 1);
    check("post_rst_sof", 32'(pix_sof), 1);
    wait_drain(1'b0);

    // Frame wrap: 25 words from row 0 after a clean reset
    do_reset();
    sof_cnt = 0;
    eof_cnt = 0;
    for (int w = 0; w < RPF + 1; w++) begin
      send(w * 3, 1'b1);
      repeat (27) @(posedge clk);
      #1;
    end
    wait_drain(1'b0);
    check("frame_eof_count", eof_cnt, 1);
    check("frame_sof_count", sof_cnt, 2);
    check("frame_row_after", 32'(row_idx), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_word_unpacker.md
Name: row_word_unpacker

Overview:
- Sits directly downstream of the camera input stage, which delivers one 208-bit parallel row word (26 x 8-bit pixels) per dout_vald strobe.
- Buffers up to DEPTH row words and serialises them into an 8-bit pixel stream with a valid/ready handshake toward the PE array.
- Generates row/frame framing flags and row/column indices.
- Runs entirely in the PE-side clock domain. Input strobe is already synchronised into clk before arriving here.

Parameters:
- WORD_W, 208, width of one input row word.
- PIX_W, 8, pixel width; WORD_W must be a multiple of PIX_W.
- PIX_PER_WORD, WORD_W/PIX_W (26), pixels per row word; derived, not overridden.
- ROWS_PER_FRAME, 24, row words per frame.
- DEPTH, 2, row-word buffer entries (power of 2, >=2).

Ports:
- clk  in  1  block clock
- rst  in  1  synchronous reset, active-high
- en  in  1  accept enable; when 0, din_vald is ignored (draining continues)
- din_vald  in  1  one-cycle strobe: din holds a complete row word
- din  in  WORD_W  row word; pixel 0 = din[7:0], pixel 25 = din[207:200]
- pix_data  out  PIX_W  current pixel
- pix_vld  out  1  pix_data valid
- pix_rdy  in  1  consumer ready; transfer when pix_vld && pix_rdy
- pix_sol  out  1  current pixel is column 0
- pix_eol  out  1  current pixel is column PIX_PER_WORD-1
- pix_sof  out  1  column 0 of row 0
- pix_eof  out  1  last column of row ROWS_PER_FRAME-1
- col_idx  out  5  column of current pixel
- row_idx  out  5  row of current pixel within frame
- level  out  2  buffered words, including the one being read (0..DEPTH)
- overflow  out  1  sticky: a row word was dropped

Behaviour:
- Reset (rst=1 at a clk edge): pix_vld=0, pix_data=0, all flags=0, col_idx=0, row_idx=0, level=0, overflow=0, FSM=EMPTY. Reset mid-row discards all buffered data.
- Buffer: circular, DEPTH entries, separate write and read pointers, plus an occupancy count (level).
- Write: occurs when en && din_vald and the buffer is not full, or is full but the final pixel of the head word transfers in the same cycle.
- Drop: a write with the buffer full and no same-cycle free is dropped. overflow is set to 1 and held until rst. Buffer contents are unaffected.
- FSM states:
  - EMPTY: pix_vld=0. Moves to STREAM the cycle after a write.
  - STREAM: pix_vld=1; head word is read.
- Latency: din_vald at edge N into an empty buffer gives pix_vld=1 with pixel 0 after edge N+1. Only one bubble cycle is allowed.
- Transfer: on pix_vld && pix_rdy, col_idx increments. pix_data and all flags update in the same registered step, with no gap between pixels.
- pix_data must hold stable while pix_vld && !pix_rdy. Flags and indices also hold stable.
- Row end (transfer at col_idx=PIX_PER_WORD-1):
  - col_idx wraps to 0 and the head word is freed.
  - row_idx increments, wrapping from ROWS_PER_FRAME-1 to 0.
  - If another word is buffered, go directly to its pixel 0 the next cycle with no bubble. Otherwise go to EMPTY.
- Simultaneous write and free: level is unchanged.
- Flags are combinational decodes of the registered col_idx/row_idx:
  - pix_sol = (col_idx==0)
  - pix_eol = (col_idx==PIX_PER_WORD-1)
  - pix_sof = sol && row_idx==0
  - pix_eof = eol && row_idx==ROWS_PER_FRAME-1
  - All flags are gated by pix_vld.
- en deassert mid-stream: buffered words still drain fully. Only new writes are blocked.
- Arithmetic: counters are unsigned. No pixel data is modified.

Test Plan:
- Single word: rst, then din=208'h19_18_…_01_00 (byte k = k) pulsed once, pix_rdy=1. Pix_vld rises 1 cycle later; pix_data = 0,1,…,25 on consecutive cycles. pix_sol with 0, pix_eol with 25, pix_sof with 0; then pix_vld=0, level=0.
- Back-to-back words: 2 words 10 cycles apart, pix_rdy=1. 52 contiguous pixels with no gap; row_idx 0 then 1; second word's pixel 0 follows first word's pixel 25 directly.
- Backpressure: pix_rdy toggles 1,0,0,1 repeatedly. Each pixel is held across stall cycles; output sequence is identical to the unstalled run; no duplicates or loss.
- Overflow: pix_rdy=0, 3 words pushed. level=2, overflow=1; releasing pix_rdy yields only words 1 and 2.
- Frame wrap: 24 words streamed. pix_eof asserted exactly on pixel 25 of row 23; the next word starts with row_idx=0 and pix_sof=1.
- Reset mid-row: rst asserted at pixel 10 of row 3. Next cycle pix_vld=0, level=0, overflow=0; the next word starts at row 0, col 0.
